// File: rtl/joy_db9md_multi.sv
// Multi-port Megadrive/SMS DB9 pad scanner with a shared select line.
// Define JOYDB9MD_DEBOUNCE_EN to publish a word only after two equal frames.
module joy_db9md_multi #(
  parameter int NUM_PORTS    = 2,
  parameter int PHASE_CYCLES = 512,
  parameter int FRAME_STEPS  = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [6*NUM_PORTS-1:0] joy_in,
  output logic                   joy_mdsel,
  output logic [12*NUM_PORTS-1:0] joystick,
  output logic [NUM_PORTS-1:0]   six_btn,
  output logic [NUM_PORTS-1:0]   md_pad,
  output logic                   frame_valid
);

  localparam int PW = $clog2(PHASE_CYCLES);
  localparam int SW = $clog2(FRAME_STEPS);

  localparam logic [SW-1:0] ST_LOAD = SW'(2);
  localparam logic [SW-1:0] ST_MD   = SW'(3);
  localparam logic [SW-1:0] ST_SIX  = SW'(5);
  localparam logic [SW-1:0] ST_XYZ  = SW'(6);
  localparam logic [SW-1:0] ST_PUB  = SW'(7);

  logic [PW-1:0] pcnt;
  logic [SW-1:0] step;
  logic          tick;

  logic [6*NUM_PORTS-1:0] sync1;
  logic [6*NUM_PORTS-1:0] sync2;

  assign tick = (pcnt == PW'(PHASE_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt <= '0;
      step <= '0;
    end else begin
      pcnt <= tick ? '0 : pcnt + 1'b1;
      if (tick)
        step <= (step == SW'(FRAME_STEPS - 1)) ? '0 : step + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= joy_in;
      sync2 <= sync1;
    end
  end

  // Even steps 0..6 drive select low; every other step leaves it high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      joy_mdsel   <= 1'b1;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= tick && (step == ST_PUB);
      if (tick)
        joy_mdsel <= (step >= SW'(7)) || step[0];
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [5:0]  s;
    logic [11:0] raw;
    logic [11:0] word;
    logic [11:0] pub;
    logic        six;
    logic        md;
    logic        six_q;
    logic        md_q;
`ifdef JOYDB9MD_DEBOUNCE_EN
    logic [11:0] hist;
`endif

    assign s    = sync2[6*p +: 6];
    assign word = ~{raw[8], raw[7], raw[11:9],
                    raw[5:4], raw[6], raw[3:0]};

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        raw <= 12'hFFF;
        six <= 1'b0;
        md  <= 1'b0;
      end else if (tick) begin
        unique case (1'b1)
          step == ST_LOAD: begin
            raw[5:0]  <= s;
            raw[11:6] <= 6'h3F;
            six       <= 1'b0;
          end
          step == ST_MD: begin
            // L and R both low while select is low marks a Megadrive pad
            if (s[1:0] == 2'b00) begin
              raw[7:6] <= s[5:4];
              md       <= 1'b1;
            end else begin
              md <= 1'b0;
            end
          end
          step == ST_SIX: begin
            if (s[3:0] == 4'h0)
              six <= 1'b1;
          end
          step == ST_XYZ: begin
            if (six)
              raw[11:8] <= s[3:0];
          end
          default: ;
        endcase
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        pub   <= '0;
        six_q <= 1'b0;
        md_q  <= 1'b0;
`ifdef JOYDB9MD_DEBOUNCE_EN
        hist  <= '0;
`endif
      end else if (tick && step == ST_PUB) begin
        six_q <= six;
        md_q  <= md;
`ifdef JOYDB9MD_DEBOUNCE_EN
        hist  <= word;
        if (word == hist)
          pub <= word;
`else
        pub   <= word;
`endif
      end
    end

    assign joystick[12*p +: 12] = pub;
    assign six_btn[p]           = six_q;
    assign md_pad[p]            = md_q;
  end

endmodule

// File: tb/tb_joy_db9md_multi.sv
// Table-driven scoreboard bench for joy_db9md_multi
// with behavioural SMS / 3-button / 6-button pad models.
module tb_joy_db9md_multi;

  localparam logic [1:0] ABS = 2'd0;
  localparam logic [1:0] SMS = 2'd1;
  localparam logic [1:0] MD3 = 2'd2;
  localparam logic [1:0] MD6 = 2'd3;

  typedef struct {
    logic [1:0]  t0;
    logic [11:0] b0;
    logic [1:0]  t1;
    logic [11:0] b1;
    logic [11:0] w0;
    logic [11:0] w1;
    logic [1:0]  six;
    logic [1:0]  md;
  } vec_t;

  typedef struct {
    logic [11:0] w0;
    logic [11:0] w1;
    logic [1:0]  six;
    logic [1:0]  md;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [11:0] joy_in;
  logic        joy_mdsel;
  logic [23:0] joystick;
  logic [1:0]  six_btn;
  logic [1:0]  md_pad;
  logic        frame_valid;

  logic [1:0]  t0, t1;
  logic [11:0] b0, b1;
  logic [1:0]  fall_cnt;

  int tests;
  int fails;

  exp_t sb[$];
  logic [11:0] mprev0, mprev1, mpub0, mpub1;

  joy_db9md_multi #(
    .NUM_PORTS   (2),
    .PHASE_CYCLES(4),
    .FRAME_STEPS (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .joy_in     (joy_in),
    .joy_mdsel  (joy_mdsel),
    .joystick   (joystick),
    .six_btn    (six_btn),
    .md_pad     (md_pad),
    .frame_valid(frame_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // b bits: 0 R,1 L,2 D,3 U,4 A,5 B,6 C,7 X,8 Y,9 Z,10 S,11 M
  function automatic logic [5:0] pad(
    input logic [1:0]  t,
    input logic [11:0] b,
    input logic        sel,
    input logic [1:0]  c
  );
    logic [5:0] r;
    r = 6'h3F;
    case (t)
      SMS: r = ~{b[6], b[5], b[3], b[2], b[1], b[0]};
      MD3, MD6: begin
        if (sel) begin
          if (t == MD6 && c == 2'd3)
            r = ~{b[6], b[5], b[9], b[8], b[7], b[11]};
          else
            r = ~{b[6], b[5], b[3], b[2], b[1], b[0]};
        end else begin
          if (t == MD6 && c == 2'd3)
            r = {~b[10], ~b[4], 4'b0000};
          else
            r = {~b[10], ~b[4], ~b[3], ~b[2], 2'b00};
        end
      end
      default: r = 6'h3F;
    endcase
    return r;
  endfunction

  always @(negedge joy_mdsel or posedge reset)
    if (reset) fall_cnt <= 2'd0;
    else       fall_cnt <= fall_cnt + 2'd1;

  assign joy_in = {pad(t1, b1, joy_mdsel, fall_cnt),
                   pad(t0, b0, joy_mdsel, fall_cnt)};

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mprev0 = '0; mprev1 = '0;
    mpub0  = '0; mpub1  = '0;
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    t0 = v.t0; b0 = v.b0;
    t1 = v.t1; b1 = v.b1;
`ifdef JOYDB9MD_DEBOUNCE_EN
    if (v.w0 == mprev0) mpub0 = v.w0;
    if (v.w1 == mprev1) mpub1 = v.w1;
`else
    mpub0 = v.w0;
    mpub1 = v.w1;
`endif
    mprev0 = v.w0;
    mprev1 = v.w1;
    e.w0 = mpub0; e.w1 = mpub1;
    e.six = v.six; e.md = v.md;
    sb.push_back(e);
  endtask

  task automatic wait_fv(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!frame_valid && n < 100);
    if (!frame_valid) begin
      fails++;
      $display("FAIL fv_timeout: got none expected pulse");
    end
  endtask

  task automatic check_frame(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL %s_sb: got empty expected entry", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_w0"},  32'(joystick[11:0]),  32'(e.w0));
    chk({tag, "_w1"},  32'(joystick[23:12]), 32'(e.w1));
    chk({tag, "_six"}, 32'(six_btn),         32'(e.six));
    chk({tag, "_md"},  32'(md_pad),          32'(e.md));
  endtask

  vec_t vecs[12];

  initial begin
    int n;
    int sel_n;
    vec_t v;

    vecs[0]  = '{MD3, 12'h011, ABS, 12'h000,
                 12'h011, 12'h000, 2'b00, 2'b01};
    vecs[1]  = '{MD6, 12'h480, ABS, 12'h000,
                 12'h480, 12'h000, 2'b01, 2'b01};
    vecs[2]  = '{MD3, 12'h008, SMS, 12'h020,
                 12'h008, 12'h020, 2'b00, 2'b01};
    vecs[3]  = '{MD6, 12'hA55, MD3, 12'h0F2,
                 12'hA55, 12'h072, 2'b01, 2'b11};
    vecs[4]  = '{SMS, 12'h07C, MD6, 12'h300,
                 12'h06C, 12'h300, 2'b10, 2'b10};
    vecs[5]  = '{ABS, 12'h000, ABS, 12'h000,
                 12'h000, 12'h000, 2'b00, 2'b00};
    vecs[6]  = '{ABS, 12'h000, MD3, 12'h020,
                 12'h000, 12'h020, 2'b00, 2'b10};
    vecs[7]  = '{ABS, 12'h000, MD3, 12'h000,
                 12'h000, 12'h000, 2'b00, 2'b10};
    vecs[8]  = '{ABS, 12'h000, MD3, 12'h020,
                 12'h000, 12'h020, 2'b00, 2'b10};
    vecs[9]  = vecs[8];
    vecs[10] = '{MD3, 12'h011, MD6, 12'h480,
                 12'h011, 12'h480, 2'b10, 2'b11};
    vecs[11] = vecs[10];

    tests = 0;
    fails = 0;
    reset = 1'b1;
    t0 = ABS; b0 = '0;
    t1 = ABS; b1 = '0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_sel", 32'(joy_mdsel),   32'h1);
    chk("rst_joy", 32'(joystick),    32'h0);
    chk("rst_six", 32'(six_btn),     32'h0);
    chk("rst_md",  32'(md_pad),      32'h0);
    chk("rst_fv",  32'(frame_valid), 32'h0);

    apply('{ABS, 12'h000, ABS, 12'h000,
            12'h000, 12'h000, 2'b00, 2'b00});
    @(posedge clk); #1;
    reset = 1'b0;
    n = 0;
    sel_n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (!joy_mdsel && sel_n == 0) sel_n = n;
    end while (!frame_valid && n < 100);
    chk("first_sel_fall", 32'(sel_n), 32'd4);
    chk("first_fv", 32'(n), 32'd32);
    check_frame("absent");

    for (int i = 0; i < 12; i++) begin
      apply(vecs[i]);
      wait_fv(n);
      chk($sformatf("v%0d_period", i), 32'(n), 32'd32);
      check_frame($sformatf("v%0d", i));
    end

    // Reset during step 4 of the next frame.
    repeat (18) @(posedge clk);
    #1;
    chk("pre_rst_joy", 32'(joystick), 32'h480011);
    reset = 1'b1;
    #1;
    chk("mid_rst_joy", 32'(joystick),    32'h0);
    chk("mid_rst_six", 32'(six_btn),     32'h0);
    chk("mid_rst_md",  32'(md_pad),      32'h0);
    chk("mid_rst_sel", 32'(joy_mdsel),   32'h1);
    chk("mid_rst_fv",  32'(frame_valid), 32'h0);
    sb.delete();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    apply(vecs[11]);
    wait_fv(n);
    chk("post_rst_fv", 32'(n), 32'd32);
    check_frame("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/joy_db9md_multi.md
Name: joy_db9md_multi

Overview:
Parametrised successor to the single-port Megadrive DB9 reader. It scans NUM_PORTS Megadrive/SMS pads through one shared select line (pin 7) and auto-detects SMS, 3-button and 6-button pads per port. It publishes active-high 12-bit button words once per frame. The whole block runs on one clock with a clock-enable prescaler (no derived clocks) and sits between the DB9 splitter pins and core input logic.

Parameters:
NUM_PORTS, 2, number of pads scanned (1..4)
PHASE_CYCLES, 512, clk cycles per scan step (>=4)
FRAME_STEPS, 64, scan steps per frame (8..256); steps 8..FRAME_STEPS-1 are idle with select high (6-button pad timeout)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
joy_in  input  6*NUM_PORTS  raw pad pins per port p at [6p+5:6p] = C B U D L R, active-low
joy_mdsel  output  1  shared select to pin 7 of all ports
joystick  output  12*NUM_PORTS  port p at [12p+11:12p] = M S Z Y X C B A U D L R, active-high
six_btn  output  NUM_PORTS  1 = port p detected as 6-button in last frame
md_pad  output  NUM_PORTS  1 = port p detected as Megadrive pad (3 or 6 button)
frame_valid  output  1  one-clk pulse when joystick/six_btn/md_pad update

Behaviour:
- Reset values: joy_mdsel=1, joystick=0, six_btn=0, md_pad=0, frame_valid=0, prescaler=0, step=0.
- Reset values (internal): per-port raw work reg=12'hFFF, synchronisers=all 1. Reset mid-frame aborts the scan; the scan restarts at step 0 after reset release.
- joy_in passes through a 2-flop synchroniser per bit (reset value 1).
- Prescaler counts 0..PHASE_CYCLES-1. Tick occurs when count = PHASE_CYCLES-1, then it wraps to 0. The first tick comes PHASE_CYCLES clocks after reset release.
- On each tick the current step acts using the synchronised sample s, then step increments modulo FRAME_STEPS. Frame period = FRAME_STEPS*PHASE_CYCLES clocks.
- Raw work reg bit order: 0 R, 1 L, 2 D, 3 U, 4 B, 5 C, 6 A, 7 S, 8 M, 9 X, 10 Y, 11 Z. Per-port actions on each step:
  step 0: sel<=0.
  step 1: sel<=1.
  step 2: raw[5:0]<=s[5:0]; raw[11:6]<=6'h3F; six<=0; sel<=0.
  step 3: if s[1:0]==00 then raw[7:6]<=s[5:4] and md<=1, else md<=0 (SMS pad; A/S stay released); sel<=1.
  step 4: sel<=0.
  step 5: if s[3:0]==0000 then six<=1; sel<=1.
  step 6: if six then raw[11:8]<=s[3:0]; sel<=0.
  step 7: publish joystick[12p+:12] = ~{raw[8],raw[7],raw[11:9],raw[5:4],raw[6],raw[3:0]}; six_btn[p]<=six; md_pad[p]<=md; frame_valid=1 for exactly one clk; sel<=1.
  steps 8..FRAME_STEPS-1: sel<=1.
- joy_mdsel is a registered output and changes only on tick edges.
- Each port's sample for a step reflects the select level held for a full PHASE_CYCLES period.
- Ports are fully independent: one port's pad type or absence never affects another port's word.
- Absent pad (all inputs pulled high) reads as SMS with no buttons: joystick=0, md=0, six=0.

Optional Feature:
JOYDB9MD_DEBOUNCE_EN: when defined, a port's published word updates only if the step-7 word equals the previous frame's step-7 word; otherwise the old word is held. frame_valid still pulses every frame. The comparison history resets to 0.
When undefined, every frame publishes directly (one frame latency).

Test Plan:
- Bench setup for all scenarios: PHASE_CYCLES=4, FRAME_STEPS=8, NUM_PORTS=2, behavioural pad models driven by joy_mdsel.
- Assert reset -> joy_mdsel=1, joystick=0, six_btn=0, md_pad=0, frame_valid=0; release -> first mdsel fall after 4 clks, frame_valid every 32 clks.
- Port0 3-button pad, A+Right held -> after first frame_valid joystick[11:0]=12'h011, md_pad[0]=1, six_btn[0]=0.
- Port0 6-button pad, X+Start held -> joystick[11:0]=12'h480, six_btn[0]=1, md_pad[0]=1.
- Port1 SMS pad (no select response), button 1 (pin6) held, port0 3-button with Up -> joystick[23:12]=12'h020, md_pad[1]=0, joystick[11:0]=12'h008.
- Assert reset at step 4 of a frame with buttons held -> outputs clear immediately, mdsel=1. No frame_valid until a full 32-clk frame completes post-release, then correct word.
- With JOYDB9MD_DEBOUNCE_EN, press B for exactly one frame -> joystick stays 0. Hold B for two frames -> 12'h020 on the second frame_valid.
